// File: rtl/axi_rd_pkg.sv
// Shared types and constants for the two-requester AXI3 read arbiter.
// Round-robin tie-breaking is selected by defining AXI_RD_RR_EN.
package axi_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_idx_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] ID_INST_DEF    = 4'd0;
    localparam logic [3:0] ID_DATA_DEF    = 4'd1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way grant logic. With AXI_RD_RR_EN the requester not granted last wins a
// tie; without it the data requester always wins a tie.
module arb_rr2
    import axi_rd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt,
    output req_idx_t   gnt_idx
);

    req_idx_t last;

    // Reset to inst so data takes the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= REQ_INST;
        end else if (advance) begin
            last <= gnt_idx;
        end
    end

`ifdef AXI_RD_RR_EN
    always_comb begin
        gnt_idx = REQ_DATA;
        if (req[REQ_INST] && req[REQ_DATA]) begin
            gnt_idx = (last == REQ_DATA) ? REQ_INST : REQ_DATA;
        end else if (req[REQ_INST]) begin
            gnt_idx = REQ_INST;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt_idx = req[REQ_DATA] ? REQ_DATA : REQ_INST;
    end
`endif

    always_comb begin
        gnt = '0;
        if (|req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Single-outstanding AXI3 read arbiter for inst-fetch and dcache-miss requesters.
// Define AXI_RD_RR_EN for round-robin tie-breaking (default: data wins ties).
module axi_rd_arbiter
    import axi_rd_pkg::*;
#(
    parameter int         ADDR_W  = 32,
    parameter int         DATA_W  = 32,
    parameter logic [3:0] ID_INST = ID_INST_DEF,
    parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              inst_req_valid,
    output logic              inst_req_ready,
    input  logic [ADDR_W-1:0] inst_req_addr,
    input  logic [7:0]        inst_req_len,
    input  logic [2:0]        inst_req_size,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_rlast,
    output logic [1:0]        inst_rresp,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic [7:0]        data_req_len,
    input  logic [2:0]        data_req_size,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_rlast,
    output logic [1:0]        data_rresp,

    output logic [3:0]        arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic [1:0]        arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [3:0]        rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready,

    output logic              err_id
);

    state_t     state;
    req_idx_t   owner;
    req_idx_t   gnt_idx;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       req_hs;

    assign req    = {data_req_valid, inst_req_valid};
    assign req_hs = aresetn && (state == IDLE) && (|req);

    arb_rr2 u_arb (
        .clk     (aclk),
        .rst_n   (aresetn),
        .req     (req),
        .advance (req_hs),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Ready is only offered while idle; aresetn gating keeps it low during reset.
    assign inst_req_ready = req_hs && gnt[REQ_INST];
    assign data_req_ready = req_hs && gnt[REQ_DATA];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state   <= IDLE;
            owner   <= REQ_INST;
            arid    <= '0;
            araddr  <= '0;
            arlen   <= '0;
            arsize  <= '0;
            arvalid <= 1'b0;
            rready  <= 1'b0;
            err_id  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        owner   <= gnt_idx;
                        arvalid <= 1'b1;
                        state   <= ADDR;
                        if (gnt_idx == REQ_DATA) begin
                            arid   <= ID_DATA;
                            araddr <= data_req_addr;
                            arlen  <= data_req_len;
                            arsize <= data_req_size;
                        end else begin
                            arid   <= ID_INST;
                            araddr <= inst_req_addr;
                            arlen  <= inst_req_len;
                            arsize <= inst_req_size;
                        end
                    end
                end
                ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (rvalid) begin
                        // Mismatched beats still go to the owner; only flag them.
                        if (rid != arid) begin
                            err_id <= 1'b1;
                        end
                        if (rlast) begin
                            rready <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    arvalid <= 1'b0;
                    rready  <= 1'b0;
                end
            endcase
        end
    end

    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign inst_rvalid = rvalid && rready && (owner == REQ_INST);
    assign data_rvalid = rvalid && rready && (owner == REQ_DATA);
    assign inst_rdata  = rdata;
    assign data_rdata  = rdata;
    assign inst_rlast  = rlast;
    assign data_rlast  = rlast;
    assign inst_rresp  = rresp;
    assign data_rresp  = rresp;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter; tie expectations follow AXI_RD_RR_EN.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        inst_req_valid, data_req_valid;
    logic        inst_req_ready, data_req_ready;
    logic [31:0] inst_req_addr, data_req_addr;
    logic [7:0]  inst_req_len, data_req_len;
    logic [2:0]  inst_req_size, data_req_size;
    logic        inst_rvalid, data_rvalid;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_rlast, data_rlast;
    logic [1:0]  inst_rresp, data_rresp;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic        err_id;

    int n_run  = 0;
    int n_fail = 0;

    always #5 aclk = ~aclk;

    axi_rd_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready),
        .inst_req_addr(inst_req_addr), .inst_req_len(inst_req_len), .inst_req_size(inst_req_size),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata), .inst_rlast(inst_rlast), .inst_rresp(inst_rresp),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready),
        .data_req_addr(data_req_addr), .data_req_len(data_req_len), .data_req_size(data_req_size),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_rlast(data_rlast), .data_rresp(data_rresp),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .err_id(err_id)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        @(negedge aclk);
    endtask

    task automatic beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        rvalid = 1'b1; rid = id; rdata = d; rlast = last; rresp = 2'b00;
    endtask

    task automatic no_beat();
        rvalid = 1'b0; rlast = 1'b0; rid = 4'd0; rdata = '0;
    endtask

    logic exp_data_win;

    initial begin
        aresetn = 1'b0;
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        inst_req_addr = '0; data_req_addr = '0;
        inst_req_len = '0; data_req_len = '0;
        inst_req_size = '0; data_req_size = '0;
        arready = 1'b0; rresp = 2'b00;
        no_beat();

        // Reset state, with a requester and a stray beat present.
        inst_req_valid = 1'b1;
        rvalid = 1'b1;
        settle();
        chk("rst_inst_ready", inst_req_ready, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rready", rready, 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_inst_rvalid", inst_rvalid, 0);
        chk("rst_arburst", arburst, 2'b01);
        tick();
        inst_req_valid = 1'b0; no_beat();
        aresetn = 1'b1;
        tick();

        // Inst-only burst, arready held off two cycles.
        inst_req_valid = 1'b1; inst_req_addr = 32'h1C00_0000; inst_req_len = 8'd3; inst_req_size = 3'd2;
        settle();
        chk("t1_inst_ready", inst_req_ready, 1);
        chk("t1_data_ready", data_req_ready, 0);
        tick();
        inst_req_valid = 1'b0; inst_req_addr = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            arready = (c == 2);
            settle();
            chk("t1_arvalid", arvalid, 1);
            chk("t1_araddr", araddr, 32'h1C00_0000);
            tick();
        end
        arready = 1'b0;
        settle();
        chk("t1_arid", arid, 0);
        chk("t1_arlen", arlen, 3);
        chk("t1_arsize", arsize, 2);
        chk("t1_arvalid_drop", arvalid, 0);
        for (int b = 0; b < 4; b++) begin
            beat(4'd0, 32'hA000_0000 + b, b == 3);
            settle();
            chk("t1_rready", rready, 1);
            chk("t1_inst_rvalid", inst_rvalid, 1);
            chk("t1_data_rvalid", data_rvalid, 0);
            chk("t1_inst_rdata", inst_rdata, 32'hA000_0000 + b);
            chk("t1_inst_rlast", inst_rlast, (b == 3));
            tick();
        end
        no_beat();
        settle();
        chk("t1_idle_rready", rready, 0);
        chk("t1_err_id", err_id, 0);

        // Simultaneous requests: data wins first tie in either mode.
        tick();
        inst_req_valid = 1'b1; inst_req_addr = 32'h0000_1000; inst_req_len = 8'd0;
        data_req_valid = 1'b1; data_req_addr = 32'h8000_0040; data_req_len = 8'd1; data_req_size = 3'd2;
        settle();
        chk("t2_data_ready", data_req_ready, 1);
        chk("t2_inst_ready", inst_req_ready, 0);
        tick();
        data_req_valid = 1'b0;
        arready = 1'b1;
        settle();
        chk("t2_arid_data", arid, 1);
        chk("t2_araddr", araddr, 32'h8000_0040);
        chk("t2_inst_wait", inst_req_ready, 0);
        tick();
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            beat(4'd1, 32'hD000_0000 + b, b == 1);
            settle();
            chk("t2_data_rvalid", data_rvalid, 1);
            chk("t2_inst_rvalid", inst_rvalid, 0);
            chk("t2_inst_wait_r", inst_req_ready, 0);
            tick();
        end
        no_beat();
        settle();
        chk("t2_inst_granted", inst_req_ready, 1);
        tick();
        inst_req_valid = 1'b0;
        arready = 1'b1;
        settle();
        chk("t2_arid_inst", arid, 0);
        chk("t2_araddr_inst", araddr, 32'h0000_1000);
        tick();
        arready = 1'b0;
        beat(4'd0, 32'h1111_1111, 1'b1);
        tick();
        no_beat();

        // Both held valid for four back-to-back single-beat transactions; last grant was inst.
        inst_req_valid = 1'b1; data_req_valid = 1'b1;
        data_req_len = 8'd0;
        for (int g = 0; g < 4; g++) begin
`ifdef AXI_RD_RR_EN
            exp_data_win = (g % 2 == 0);
`else
            exp_data_win = 1'b1;
`endif
            settle();
            chk("t3_data_ready", data_req_ready, exp_data_win);
            chk("t3_inst_ready", inst_req_ready, !exp_data_win);
            tick();
            arready = 1'b1;
            settle();
            chk("t3_arid", arid, exp_data_win ? 4'd1 : 4'd0);
            tick();
            arready = 1'b0;
            beat(exp_data_win ? 4'd1 : 4'd0, 32'h3000_0000 + g, 1'b1);
            settle();
            chk("t3_owner_rvalid", exp_data_win ? data_rvalid : inst_rvalid, 1);
            tick();
            no_beat();
        end
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        tick();

        // len=0 turnaround: IDLE again three cycles after the request handshake.
        inst_req_valid = 1'b1; inst_req_addr = 32'h0000_2000; inst_req_len = 8'd0;
        settle();
        chk("t4_hs", inst_req_ready, 1);
        tick();
        inst_req_addr = 32'h0000_3000;
        arready = 1'b1;
        settle();
        chk("t4_ready_in_addr", inst_req_ready, 0);
        tick();
        arready = 1'b0;
        beat(4'd0, 32'h4444_0000, 1'b1);
        settle();
        chk("t4_ready_in_data", inst_req_ready, 0);
        tick();
        no_beat();
        settle();
        chk("t4_back_to_back", inst_req_ready, 1);
        tick();
        inst_req_valid = 1'b0;
        settle();
        chk("t4_araddr2", araddr, 32'h0000_3000);
        chk("t4_arvalid2", arvalid, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(4'd0, 32'h4444_0001, 1'b1);
        tick();
        no_beat();

        // Reset in the middle of an 8-beat data burst.
        data_req_valid = 1'b1; data_req_addr = 32'h9000_0000; data_req_len = 8'd7;
        tick();
        data_req_valid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int b = 0; b < 2; b++) begin
            beat(4'd1, 32'h5000_0000 + b, 1'b0);
            settle();
            chk("t5_data_rvalid", data_rvalid, 1);
            tick();
        end
        aresetn = 1'b0;
        beat(4'd1, 32'h5000_0002, 1'b0);
        settle();
        chk("t5_rst_rready", rready, 0);
        chk("t5_rst_arvalid", arvalid, 0);
        chk("t5_rst_rvalid", data_rvalid, 0);
        tick();
        no_beat();
        aresetn = 1'b1;
        tick();
        inst_req_valid = 1'b1; inst_req_addr = 32'h0000_4000; inst_req_len = 8'd0;
        settle();
        chk("t5_post_hs", inst_req_ready, 1);
        tick();
        inst_req_valid = 1'b0;
        arready = 1'b1;
        settle();
        chk("t5_post_araddr", araddr, 32'h0000_4000);
        tick();
        arready = 1'b0;
        beat(4'd0, 32'h6666_6666, 1'b1);
        settle();
        chk("t5_post_rlast", inst_rlast && inst_rvalid, 1);
        tick();
        no_beat();
        settle();
        chk("t5_post_idle", rready, 0);
        tick();

        // rid mismatch during an inst burst is still delivered and flagged.
        inst_req_valid = 1'b1; inst_req_addr = 32'h0000_5000; inst_req_len = 8'd1;
        tick();
        inst_req_valid = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        beat(4'd2, 32'h7777_0000, 1'b0);
        settle();
        chk("t6_err_before", err_id, 0);
        chk("t6_bad_rid_inst", inst_rvalid, 1);
        chk("t6_bad_rid_data", data_rvalid, 0);
        tick();
        beat(4'd0, 32'h7777_0001, 1'b1);
        settle();
        chk("t6_err_set", err_id, 1);
        tick();
        no_beat();
        tick();
        settle();
        chk("t6_err_sticky", err_id, 1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Read-channel arbiter placed between the core's instruction-fetch and data-cache miss paths and the single AXI3 read port exported by the CPU top. Accepts burst read requests from two requesters, issues one AR transaction at a time, and steers R beats back to the owning requester. One outstanding read transaction at a time; write channels are out of scope.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, R data width
- ID_INST, 4'd0, arid used for instruction requests
- ID_DATA, 4'd1, arid used for data requests

Ports:
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, asynchronous assert, active-low
- inst_req_valid / data_req_valid  in  1  requester has a read pending
- inst_req_ready / data_req_ready  out  1  request accepted this cycle
- inst_req_addr / data_req_addr  in  ADDR_W  burst start address
- inst_req_len / data_req_len  in  8  beats minus one (AXI arlen encoding)
- inst_req_size / data_req_size  in  3  bytes per beat, log2
- inst_rvalid / data_rvalid  out  1  beat valid for this requester
- inst_rdata / data_rdata  out  DATA_W  beat data (shared copy of rdata)
- inst_rlast / data_rlast  out  1  final beat
- inst_rresp / data_rresp  out  2  beat response
- arid  out  4;  araddr  out  32;  arlen  out  8;  arsize  out  3;  arburst  out  2;  arlock  out  2;  arcache  out  4;  arprot  out  3
- arvalid  out  1;  arready  in  1
- rid  in  4;  rdata  in  32;  rresp  in  2;  rlast  in  1;  rvalid  in  1;  rready  out  1

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: winner chosen combinationally from the valid requesters; winner's req_ready=1 (the other requester's req_ready=0). On handshake, latch addr/len/size/id/owner, go to ADDR.
- ADDR: arvalid=1 with latched fields; fields stable until arready. On arvalid&arready, go to DATA.
- DATA: rready=1. Owner's rvalid=rvalid; other requester's rvalid=0. rdata/rresp/rlast forwarded unmodified. On rvalid&rlast, go to IDLE.
- Beats whose rid differs from the latched id are still routed to the owner; the mismatch sets sticky err_id (optional debug register, cleared only by reset).
- Constant outputs: arburst=2'b01 (INCR), arlock=0, arcache=0, arprot=0.
- Default priority: data over inst when both are valid in the same cycle.

## Timing
- Reset values: state=IDLE, arvalid=0, rready=0, both req_ready=0 until the first IDLE evaluation after reset release, both requester rvalid=0, AR fields 0.
- Request handshake in cycle N produces arvalid=1 in cycle N+1 (registered).
- arvalid stays high, with stable fields, until arready. This includes the case where arready is already high in N+1, giving a minimum of one ADDR cycle.
- R path is combinational with zero latency: requester sees beat in the same cycle it appears on rvalid.
- A single-beat burst (len=0) with rlast on the first beat returns to IDLE the next cycle. A new grant is then possible in that IDLE cycle, giving a 2-cycle minimum gap between AR issues.
- Requests arriving in ADDR or DATA see req_ready=0 and must hold valid and fields until accepted.
- Reset asserted mid-transaction: immediate return to IDLE and the transaction is dropped. The AXI slave shares aresetn.

## Configuration
- AXI_RD_RR_EN defined: round-robin priority. On a simultaneous request, the requester not granted last wins. The last-granted pointer resets to inst, so data wins the first tie after reset.
- Not defined: fixed priority, data always wins a tie.

## Structure
- Package axi_rd_pkg: state enum (IDLE/ADDR/DATA), AXI_BURST_INCR constant, default ID constants, requester index enum (REQ_INST/REQ_DATA).
- Sub-module arb_rr2: two-way arbiter with a grant pointer, compiled as fixed priority when AXI_RD_RR_EN is absent.

## Test plan
- Inst request only, addr 0x1C000000, len 3, size 2, arready delayed 2 cycles → arvalid held 3 cycles with stable araddr; arid=0; 4 beats reach inst_rvalid only; inst_rlast on the 4th beat; data_rvalid stays 0.
- Inst and data requests in the same cycle, fixed priority → data granted (arid=1); inst_req_ready=0 until the data burst's rlast; inst is issued on the next IDLE cycle.
- Same stimulus with AXI_RD_RR_EN, repeated 4 times with both requesters held valid → grants alternate data, inst, data, inst.
- len=0 request with arready=1 and rvalid+rlast one cycle after the AR handshake → state back at IDLE 3 cycles after req handshake; a back-to-back second request is accepted.
- aresetn pulled low in DATA after 2 of 8 beats → next cycle rready=0, arvalid=0; after release, a new request completes normally.
- Beat returned with rid=2 during an inst burst → beat delivered to inst; err_id=1 and stays set.
